// File: rtl/single_port_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// single_port_ram_arbiter_pkg
//   Shared types and helpers for the single-port RAM arbiter slice.
//   - state_e   : controller FSM states (zero-fill INIT, normal RUN)
//   - clog2     : index width for a requester count, never less than 1
//   - slice_lo  : low bit of element idx inside a packed vector of width-wide
//                 fields (requester idx lives at [slice_lo(idx,w) +: w])
// ---------------------------------------------------------------------------
package single_port_ram_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width needed to index n items; a single requester still gets one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/single_port_ram_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a registered priority pointer. The search for a
//   winner starts at pointer+1 (mod N); the pointer moves to the winner on
//   every cycle where advance is high and a grant exists.
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset (pointer -> N-1)
//     req        in   [N]  request vector
//     advance    in   1 = the current grant is consumed this cycle
//     grant      out  [N]  one-hot grant (zero when nothing requests)
//     grant_idx  out  binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
  import single_port_ram_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic                  advance,
  output logic [N-1:0]          grant,
  output logic [clog2(N)-1:0]   grant_idx
);

  localparam int IW = clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] idx;
  logic          found;
  int            cand;

  // Walk the requesters in priority order; the first asserted one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    idx       = '0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr_q) + off) % N;
      idx  = IW'(cand);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = grant_idx;
  end

  // Reset value N-1 makes requester 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// ---------------------------------------------------------------------------
// single_port_ram_arbiter
//   Shares one single-port, 1-cycle-read-latency RAM among NUM_REQ
//   valid/ready requesters with round-robin priority. Read data comes back
//   one cycle after acceptance, tagged by a one-hot rsp_valid. Optionally the
//   whole RAM is zero-filled after reset before any request is accepted.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     req_valid/ready/we     per-requester handshake and write flag
//     req_addr, req_data     packed per-requester address / write data
//     rsp_valid, rsp_data    one-hot read response and its data
//     init_done              high once normal operation is reached
//     ram_we/addr/data       drive to the RAM macro
//     ram_out                RAM read data (registered inside the macro)
// ---------------------------------------------------------------------------
module single_port_ram_arbiter
  import single_port_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             init_done,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_data,
  input  logic [DATA_WIDTH-1:0]            ram_out
);

  localparam int                    IW          = clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_e                RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  // Unpacked views of the packed request payloads.
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
    end
  endgenerate

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,       cnt_d;
  logic                  init_done_q, init_done_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         win_idx;
  logic                  transfer;

  // Requests are only visible to the arbiter in RUN and out of reset, so
  // grant doubles as req_ready and a grant always means a transfer.
  assign arb_req  = (rst_n && (state_q == ST_RUN)) ? req_valid : '0;
  assign transfer = |grant;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = ram_out;
  assign init_done = init_done_q;

  // RAM port mux. Idle cycles park the address on the last granted one.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = last_addr_q;
    ram_data = '0;
    if (!rst_n) begin
      ram_addr = '0;
    end else if (state_q == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = cnt_q;
    end else if (transfer) begin
      ram_we   = req_we[win_idx];
      ram_addr = addr_arr[win_idx];
      ram_data = data_arr[win_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = '0;
    last_addr_d = last_addr_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        // The final zero write still issues this cycle.
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (transfer) begin
          last_addr_d = addr_arr[win_idx];
          if (!req_we[win_idx]) rsp_valid_d = grant;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      init_done_q <= ~INIT_ON_RESET;
      rsp_valid_q <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      last_addr_q <= last_addr_d;
    end
  end

endmodule
